// File: rtl/sips4_mem_unit.sv
// SIPS4 memory subsystem: 16x4 simple dual-port data RAM (rising edge)
// and a 16x16 instruction ROM fetched on the falling edge.
module sips4_mem_unit #(
    parameter int unsigned RAM_AW = 4,
    parameter int unsigned RAM_DW = 4,
    parameter int unsigned ROM_AW = 4,
    parameter int unsigned ROM_DW = 16,
    parameter logic [(2**ROM_AW)*ROM_DW-1:0] ROM_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RAM_DW-1:0] ram_data,
    input  logic [RAM_AW-1:0] ram_wraddress,
    input  logic              ram_wren,
    input  logic [RAM_AW-1:0] ram_rdaddress,
    output logic [RAM_DW-1:0] ram_q,
    input  logic [ROM_AW-1:0] rom_address,
    output logic [ROM_DW-1:0] rom_q
);

    localparam int unsigned RAM_DEPTH = 2**RAM_AW;

    logic [RAM_DW-1:0] mem_q [RAM_DEPTH];
    logic [RAM_DW-1:0] mem_d [RAM_DEPTH];
    logic [RAM_DW-1:0] ram_q_q;
    logic [ROM_DW-1:0] rom_q_q;
    logic [ROM_DW-1:0] rom_word_d;

    // Next RAM image: single-word update when write-enabled.
    always_comb begin
        mem_d = mem_q;
        if (ram_wren) begin
            mem_d[ram_wraddress] = ram_data;
        end
    end

    // Read uses the pre-edge array, so read-during-write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            ram_q_q <= '0;
        end else begin
            mem_q   <= mem_d;
            ram_q_q <= mem_q[ram_rdaddress];
        end
    end

    always_comb begin
        rom_word_d = ROM_INIT[32'(rom_address) * ROM_DW +: ROM_DW];
    end

    // Falling-edge fetch gives the core a stable word by its next rising edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_q_q <= '0;
        end else begin
            rom_q_q <= rom_word_d;
        end
    end

    assign ram_q = ram_q_q;
    assign rom_q = rom_q_q;

endmodule

// File: tb/tb_sips4_mem_unit.sv
// Self-checking bench for sips4_mem_unit: directed cases plus random traffic
// compared against an array model of the RAM and an arithmetic ROM rule.
module tb_sips4_mem_unit;

    function automatic logic [255:0] build_rom();
        logic [255:0] img;
        img = '0;
        for (int k = 0; k < 16; k++) begin
            img[k*16 +: 16] = {4{4'(k)}};
        end
        return img;
    endfunction

    localparam logic [255:0] ROM_IMG = build_rom();

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ram_data = 4'h0;
    logic [3:0] ram_wraddress = 4'h0;
    logic       ram_wren = 1'b0;
    logic [3:0] ram_rdaddress = 4'h0;
    logic [3:0] ram_q;
    logic [3:0] rom_address = 4'h0;
    logic [15:0] rom_q;

    int n_chk = 0;
    int n_pass = 0;
    logic [3:0] mdl [16];

    sips4_mem_unit #(
        .RAM_AW(4), .RAM_DW(4), .ROM_AW(4), .ROM_DW(16), .ROM_INIT(ROM_IMG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ram_data(ram_data), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
        .ram_rdaddress(ram_rdaddress), .ram_q(ram_q),
        .rom_address(rom_address), .rom_q(rom_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    function automatic logic [15:0] rom_rule(input logic [3:0] a);
        return 16'(a) * 16'h1111;
    endfunction

    // One full clock: drive, check ROM after falling edge, check RAM after rising edge.
    task automatic do_cycle(input logic wren, input logic [3:0] wa, input logic [3:0] wd,
                            input logic [3:0] ra, input logic [3:0] romaddr);
        logic [3:0] exp;
        ram_wren = wren; ram_wraddress = wa; ram_data = wd;
        ram_rdaddress = ra; rom_address = romaddr;
        @(negedge clk); #1;
        check("rom_fetch", rom_q, rom_rule(romaddr));
        @(posedge clk);
        exp = mdl[ra];
        if (wren) mdl[wa] = wd;
        #1;
        check("ram_q", 16'(ram_q), 16'(exp));
        check("rom_hold", rom_q, rom_rule(romaddr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 4'h0;

        // Reset held across edges with a write attempt pending.
        ram_wren = 1'b1; ram_data = 4'hF; ram_wraddress = 4'h3; ram_rdaddress = 4'h3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_q", 16'(ram_q), 16'h0);
        check("rst_rom_q", rom_q, 16'h0);
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) do_cycle(1'b0, 4'h0, 4'h0, 4'(a), 4'(a));

        // Write/readback at middle and top address.
        do_cycle(1'b1, 4'h3, 4'hA, 4'h0, 4'h1);
        do_cycle(1'b1, 4'hF, 4'h5, 4'h0, 4'h2);
        do_cycle(1'b0, 4'h0, 4'h0, 4'h3, 4'h3);
        do_cycle(1'b0, 4'h0, 4'h0, 4'hF, 4'hF);

        // Read-during-write returns old data, new data on following edge.
        do_cycle(1'b1, 4'h7, 4'h2, 4'h0, 4'h4);
        do_cycle(1'b1, 4'h7, 4'h9, 4'h7, 4'h5);
        do_cycle(1'b0, 4'h0, 4'h0, 4'h7, 4'h6);

        // Disabled write must not disturb memory.
        do_cycle(1'b1, 4'h1, 4'h6, 4'h0, 4'h7);
        do_cycle(1'b0, 4'h1, 4'hC, 4'h0, 4'h8);
        do_cycle(1'b0, 4'h0, 4'h0, 4'h1, 4'h9);

        for (int n = 0; n < 200; n++) begin
            do_cycle(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Asynchronous reset pulse between edges.
        ram_wren = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ram_q", 16'(ram_q), 16'h0);
        check("async_rom_q", rom_q, 16'h0);
        rst_n = 1'b1;
        #1;
        check("post_rel_rom_q", rom_q, 16'h0);
        for (int i = 0; i < 16; i++) mdl[i] = 4'h0;
        for (int a = 0; a < 16; a++) do_cycle(1'b0, 4'h0, 4'h0, 4'(a), 4'(15 - a));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sips4_mem_unit.md
Name: sips4_mem_unit

Overview:
- Memory subsystem for the SIPS4 4-bit processor core.
- Contains a simple dual-port data RAM (16 x 4 bit) and a read-only instruction ROM (16 x 16 bit).
- Both memories share one clock.
- The RAM is read and written on the rising edge. The ROM is fetched on the falling edge, so an instruction addressed by PC is stable before the core's next rising edge.

Parameters:
- RAM_AW, 4, RAM address width (depth = 2**RAM_AW words).
- RAM_DW, 4, RAM data width.
- ROM_AW, 4, ROM address width (depth = 2**ROM_AW words).
- ROM_DW, 16, ROM word width.
- ROM_INIT, all zeros, flattened ROM image of (2**ROM_AW)*ROM_DW bits. Word k occupies bits [k*ROM_DW+ROM_DW-1 : k*ROM_DW].

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- ram_data  input  RAM_DW  RAM write data.
- ram_wraddress  input  RAM_AW  RAM write address.
- ram_wren  input  1  RAM write enable, active high.
- ram_rdaddress  input  RAM_AW  RAM read address.
- ram_q  output  RAM_DW  registered RAM read data.
- rom_address  input  ROM_AW  ROM fetch address.
- rom_q  output  ROM_DW  registered ROM word.

Behaviour:

Reset:
- While rst_n = 0, all 2**RAM_AW RAM words are forced to 0, and ram_q = 0, rom_q = 0, immediately and independent of clk.
- Writes are ignored during reset.
- The first rising edge after rst_n rises operates normally.
- ROM contents are never affected by reset.

RAM write:
- On posedge clk with ram_wren = 1: mem[ram_wraddress] <= ram_data.
- ram_wren = 0 leaves memory unchanged.

RAM read:
- On every posedge clk: ram_q <= mem[ram_rdaddress], independent of ram_wren.
- Latency is 1 rising edge. ram_q holds its value between edges.

RAM read-during-write (same address, same edge):
- ram_q returns the OLD stored value.
- The new value is visible from the next read edge.

RAM different-address write and read on the same edge:
- Both take effect.
- ram_q reflects the pre-edge content of the read address.

ROM:
- On every negedge clk: rom_q <= ROM_INIT word[rom_address].
- Latency is a half cycle relative to the rising edge on which the address changed.
- No write path.

Addresses:
- Full-width and unsigned; every address value is a valid word, so there is no out-of-range case.

Outputs:
- Purely registered; no combinational path from any input to ram_q or rom_q.

Test Plan:
1. Reset: hold rst_n = 0 across several edges with ram_wren = 1 and ram_data = 4'hF -> ram_q = 0 and rom_q = 0. After release, reading every address 0..15 returns 0.
2. Write/readback: write addr 3 = 4'hA, addr 15 = 4'h5, then read addr 3 and 15 -> ram_q = 4'hA one rising edge after addr 3 is presented, then 4'h5 one edge after addr 15.
3. Read-during-write: addr 7 holds 4'h2. On one edge write 4'h9 to addr 7 while reading addr 7 -> ram_q = 4'h2. On the next edge, still reading addr 7 -> ram_q = 4'h9.
4. wren low: present ram_data = 4'hC, ram_wraddress = 1, ram_wren = 0 -> a later read of addr 1 still returns the prior value.
5. ROM fetch: ROM_INIT with word k = {4'hk, 4'hk, 4'hk, 4'hk}. Step rom_address 0..15 on rising edges -> rom_q equals 16'hkkkk after each following falling edge, unchanged at the rising edge.
6. Async reset mid-operation: after writes, pulse rst_n low between clock edges -> ram_q and rom_q go to 0 without a clock edge. RAM reads back 0 everywhere. ROM fetch resumes its programmed words on the first falling edge after release.
